// File: rtl/mem_burst_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_burst_seq
// Purpose  : Burst sequencer in front of the memory controller. Accepts a
//            burst command (start address, word count, direction) and issues
//            one single-word sel/we/addr/wdata access at a time. It follows
//            the controller's ready handshake (1->0->1) and streams read data
//            back with backpressure.
// Ports    : clk_i, sys_rst_n_i        - clock, async active-low reset
//            cmd_valid_i/cmd_ready_o   - command handshake
//            cmd_we_i, cmd_addr_i, cmd_len_i (len = words - 1)
//            wr_valid_i/wr_ready_o/wr_data_i - write-data stream
//            rd_valid_o/rd_ready_i/rd_data_o - read-data stream
//            busy_o, done_o, err_o     - burst status (done/err are pulses)
//            mc_sel_o, mc_we_o, mc_addr_o, mc_wdata_o - controller request
//            mc_ready_i, mc_rdata_i    - controller status / read data
// Macro    : MEM_BURST_TIMEOUT_EN - enables the REQ timeout abort (err_o).
// Revision : 1.0 - initial release
// ============================================================================
module mem_burst_seq #(
   parameter int TIMEOUT     = 64,
   parameter int SEL_LOW_MIN = 2
) (
   input  logic        clk_i,
   input  logic        sys_rst_n_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [7:0]  cmd_addr_i,
   input  logic [7:0]  cmd_len_i,
   input  logic        wr_valid_i,
   output logic        wr_ready_o,
   input  logic [15:0] wr_data_i,
   output logic        rd_valid_o,
   input  logic        rd_ready_i,
   output logic [15:0] rd_data_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        mc_sel_o,
   output logic        mc_we_o,
   output logic [7:0]  mc_addr_o,
   output logic [15:0] mc_wdata_o,
   input  logic        mc_ready_i,
   input  logic [15:0] mc_rdata_i
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_REQ   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4,
      ST_GAP   = 3'd5
   } state_t;

   localparam logic [7:0] GAP_MIN = 8'(SEL_LOW_MIN);

   state_t      state_q;
   logic [7:0]  cnt_q;       // words remaining after the current one
   logic [7:0]  gap_q;       // cycles mc_sel has been low, saturating
   logic        wr_ready_q;
   logic        rd_valid_q;
   logic [15:0] rd_data_q;
   logic        busy_q;
   logic        done_q;
   logic        mc_sel_q;
   logic        mc_we_q;     // doubles as the latched burst direction
   logic [7:0]  mc_addr_q;   // doubles as the running word address
   logic [15:0] mc_wdata_q;

`ifdef MEM_BURST_TIMEOUT_EN
   localparam int               TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   logic [TMO_W-1:0] tmo_q;
   logic             err_q;
`endif

   always_ff @(posedge clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 8'd0;
         gap_q      <= 8'd0;
         wr_ready_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 16'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mc_sel_q   <= 1'b0;
         mc_we_q    <= 1'b0;
         mc_addr_q  <= 8'd0;
         mc_wdata_q <= 16'd0;
`ifdef MEM_BURST_TIMEOUT_EN
         tmo_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef MEM_BURST_TIMEOUT_EN
         err_q  <= 1'b0;
         tmo_q  <= '0;   // only counts while in REQ
`endif
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  mc_we_q   <= cmd_we_i;
                  mc_addr_q <= cmd_addr_i;
                  cnt_q     <= cmd_len_i;
                  busy_q    <= 1'b1;
                  if (cmd_we_i) begin
                     wr_ready_q <= 1'b1;
                     state_q    <= ST_FETCH;
                  end else begin
                     mc_sel_q <= 1'b1;
                     state_q  <= ST_REQ;
                  end
               end
            end
            ST_FETCH: begin
               if (wr_valid_i) begin
                  mc_wdata_q <= wr_data_i;
                  wr_ready_q <= 1'b0;
                  mc_sel_q   <= 1'b1;
                  state_q    <= ST_REQ;
               end
            end
            ST_REQ: begin
               // A high mc_ready here is stale; only its fall starts the word.
               if (!mc_ready_i) begin
                  state_q <= ST_WAIT;
               end
`ifdef MEM_BURST_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  mc_sel_q <= 1'b0;
                  done_q   <= 1'b1;
                  err_q    <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
`endif
            end
            ST_WAIT: begin
               if (mc_ready_i) begin
                  mc_sel_q <= 1'b0;
                  gap_q    <= 8'd1;  // first low cycle follows this edge
                  if (!mc_we_q) begin
                     rd_data_q  <= mc_rdata_i;
                     rd_valid_q <= 1'b1;
                     state_q    <= ST_RESP;
                  end else begin
                     state_q <= ST_GAP;
                  end
               end
            end
            ST_RESP: begin
               // Low time keeps accumulating while the consumer stalls.
               if (gap_q < GAP_MIN) gap_q <= gap_q + 8'd1;
               if (rd_ready_i) begin
                  rd_valid_q <= 1'b0;
                  state_q    <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_q >= GAP_MIN) begin
                  if (cnt_q == 8'd0) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     mc_addr_q <= mc_addr_q + 8'd1;   // wraps 0xFF -> 0x00
                     cnt_q     <= cnt_q - 8'd1;
                     if (mc_we_q) begin
                        wr_ready_q <= 1'b1;
                        state_q    <= ST_FETCH;
                     end else begin
                        mc_sel_q <= 1'b1;
                        state_q  <= ST_REQ;
                     end
                  end
               end else begin
                  gap_q <= gap_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready_o = (state_q == ST_IDLE);
   assign wr_ready_o  = wr_ready_q;
   assign rd_valid_o  = rd_valid_q;
   assign rd_data_o   = rd_data_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign mc_sel_o    = mc_sel_q;
   assign mc_we_o     = mc_we_q;
   assign mc_addr_o   = mc_addr_q;
   assign mc_wdata_o  = mc_wdata_q;

`ifdef MEM_BURST_TIMEOUT_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_burst_seq
// Purpose  : Self-checking bench for mem_burst_seq: directed bursts against a
//            behavioural memory-controller responder and an expected-access /
//            expected-read-data reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_burst_seq;
   localparam int SEL_LOW_MIN = 2;
   localparam int TIMEOUT     = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [7:0] cmd_addr = 8'd0, cmd_len = 8'd0;
   logic wr_valid = 1'b0, wr_ready;
   logic [15:0] wr_data = 16'd0;
   logic rd_valid, rd_ready = 1'b1;
   logic [15:0] rd_data;
   logic busy, done, err;
   logic mc_sel, mc_we;
   logic [7:0] mc_addr;
   logic [15:0] mc_wdata;
   logic mc_ready = 1'b1;
   logic [15:0] mc_rdata = 16'hDEAD;

   always #5 clk = ~clk;

   mem_burst_seq #(.TIMEOUT(TIMEOUT), .SEL_LOW_MIN(SEL_LOW_MIN)) dut (
      .clk_i(clk), .sys_rst_n_i(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
      .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
      .busy_o(busy), .done_o(done), .err_o(err),
      .mc_sel_o(mc_sel), .mc_we_o(mc_we), .mc_addr_o(mc_addr), .mc_wdata_o(mc_wdata),
      .mc_ready_i(mc_ready), .mc_rdata_i(mc_rdata)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed { logic [7:0] addr; logic we; logic [15:0] wdata; } acc_t;
   logic [15:0] mem     [256];   // responder's storage
   logic [15:0] ref_mem [256];   // model's view of memory
   acc_t        exp_acc [$];
   logic [15:0] exp_rd  [$];
   int          exp_done = 0;
   logic        exp_err  = 1'b0;
   logic [7:0]  got_addr [$];
   logic [15:0] got_rd   [$];
   logic [15:0] wd [4];
   bit          stuck = 1'b0;

   function automatic logic [15:0] pat(input logic [7:0] a);
      return {a, ~a};
   endfunction

   // Expected accesses: word i at (addr+i) mod 256; reads return model memory.
   task automatic model_burst(input logic we, input logic [7:0] a, input int len);
      logic [7:0] ad;
      acc_t t;
      for (int i = 0; i <= len; i++) begin
         ad = a + 8'(i);
         t.addr = ad; t.we = we; t.wdata = we ? wd[i] : 16'h0;
         exp_acc.push_back(t);
         if (we) ref_mem[ad] = wd[i];
         else    exp_rd.push_back(ref_mem[ad]);
      end
      exp_done++;
   endtask

   // ---------------- memory controller responder ----------------
   // ready falls 2 cycles after sel is seen, rises 4 cycles later.
   int mc_phase = 0;
   int mc_t = 0;
   initial begin
      forever begin
         @(posedge clk); #1;
         if (!rst_n || stuck) begin
            mc_phase = 0; mc_ready = 1'b1;
         end else begin
            case (mc_phase)
               0: if (mc_sel) begin mc_phase = 1; mc_t = 0; end
               1: begin
                  mc_t++;
                  if (mc_t == 2) begin mc_ready = 1'b0; mc_phase = 2; mc_t = 0; end
               end
               2: begin
                  mc_t++;
                  if (mc_t == 4) begin
                     if (mc_we) mem[mc_addr] = mc_wdata;
                     else       mc_rdata = mem[mc_addr];
                     mc_ready = 1'b1; mc_phase = 3;
                  end
               end
               default: if (!mc_sel) begin mc_phase = 0; mc_rdata = 16'hDEAD; end
            endcase
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic        prev_sel = 1'b0, prev_rdv = 1'b0, prev_rdr = 1'b0;
   logic [15:0] prev_rdd = 16'h0;
   logic [24:0] held = 25'h0;
   int          low_cnt = 100;
   acc_t        cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_sel = 1'b0; prev_rdv = 1'b0; low_cnt = 100;
      end else begin
         chk("cmd_ready_vs_busy", cmd_ready, !busy);
         if (wr_ready) chk("sel_low_in_fetch", mc_sel, 1'b0);
         if (mc_sel && !prev_sel) begin
            got_addr.push_back(mc_addr);
            chk("sel_low_gap", low_cnt >= SEL_LOW_MIN, 1'b1);
            chk("sel_while_rd_pending", rd_valid, 1'b0);
            chk("access_expected", exp_acc.size() > 0, 1'b1);
            if (exp_acc.size() > 0) begin
               cur = exp_acc.pop_front();
               chk("acc_addr", mc_addr, cur.addr);
               chk("acc_we", mc_we, cur.we);
               if (cur.we) chk("acc_wdata", mc_wdata, cur.wdata);
            end
            held = {mc_addr, mc_we, mc_wdata};
         end else if (mc_sel) begin
            chk("req_stable", {mc_addr, mc_we, mc_wdata}, held);
         end
         low_cnt = mc_sel ? 0 : low_cnt + 1;

         if (prev_rdv && !prev_rdr) chk("rd_hold", {rd_valid, rd_data}, {1'b1, prev_rdd});
         if (rd_valid && rd_ready) begin
            got_rd.push_back(rd_data);
            chk("rd_expected", exp_rd.size() > 0, 1'b1);
            if (exp_rd.size() > 0) chk("rd_data", rd_data, exp_rd.pop_front());
         end

         if (done) begin
            chk("done_expected", exp_done > 0, 1'b1);
            if (exp_done > 0) exp_done--;
            chk("err_with_done", err, exp_err);
         end else begin
            chk("err_without_done", err, 1'b0);
         end
         prev_sel = mc_sel; prev_rdv = rd_valid; prev_rdr = rd_ready; prev_rdd = rd_data;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_cmd(input logic we, input logic [7:0] a, input logic [7:0] len);
      int t = 0;
      while (!cmd_ready && t < 2000) begin @(posedge clk); #1; t++; end
      chk("cmd_ready_wait", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("cmd_accepted_busy", busy, 1'b1);
   endtask

   task automatic push_wr(input logic [15:0] d, input int dly);
      int t = 0;
      repeat (dly) begin @(posedge clk); #1; end
      wr_valid = 1'b1; wr_data = d;
      while (!wr_ready && t < 2000) begin @(posedge clk); #1; t++; end
      chk("wr_handshake", wr_ready, 1'b1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 3000) begin @(posedge clk); #1; t++; end
      chk("burst_finished", busy, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic end_checks(input string tag);
      chk({tag, "_acc_drained"}, exp_acc.size(), 0);
      chk({tag, "_rd_drained"}, exp_rd.size(), 0);
      chk({tag, "_done_seen"}, exp_done, 0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_err"}, err, 1'b0);
      chk({tag, "_wr_ready"}, wr_ready, 1'b0);
      chk({tag, "_rd_valid"}, rd_valid, 1'b0);
      chk({tag, "_rd_data"}, rd_data, 16'h0);
      chk({tag, "_mc_sel"}, mc_sel, 1'b0);
      chk({tag, "_mc_we"}, mc_we, 1'b0);
      chk({tag, "_mc_addr"}, mc_addr, 8'h0);
      chk({tag, "_mc_wdata"}, mc_wdata, 16'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int t;
      int n;
      for (int i = 0; i < 256; i++) begin
         mem[i] = pat(8'(i)); ref_mem[i] = pat(8'(i));
      end
      for (int i = 0; i < 4; i++) wd[i] = 16'h0;

      repeat (3) @(posedge clk); #1;
      check_reset("rst");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Single write
      wd[0] = 16'hA5A5;
      got_addr.delete();
      model_burst(1'b1, 8'h10, 0);
      send_cmd(1'b1, 8'h10, 8'd0);
      push_wr(16'hA5A5, 0);
      wait_idle();
      chk("wr1_mem", mem[8'h10], 16'hA5A5);
      chk("wr1_naccess", got_addr.size(), 1);
      chk("wr1_addr", got_addr[0], 8'h10);
      end_checks("wr1");

      // Read burst with address wrap
      mem[8'hFE] = 16'h1111; mem[8'hFF] = 16'h2222; mem[8'h00] = 16'h3333;
      ref_mem[8'hFE] = 16'h1111; ref_mem[8'hFF] = 16'h2222; ref_mem[8'h00] = 16'h3333;
      got_addr.delete(); got_rd.delete();
      rd_ready = 1'b1;
      model_burst(1'b0, 8'hFE, 2);
      send_cmd(1'b0, 8'hFE, 8'd2);
      wait_idle();
      chk("wrap_rd0", got_rd[0], 16'h1111);
      chk("wrap_rd1", got_rd[1], 16'h2222);
      chk("wrap_rd2", got_rd[2], 16'h3333);
      chk("wrap_addr0", got_addr[0], 8'hFE);
      chk("wrap_addr1", got_addr[1], 8'hFF);
      chk("wrap_addr2", got_addr[2], 8'h00);
      end_checks("wrap");

      // Read backpressure
      got_addr.delete(); got_rd.delete();
      rd_ready = 1'b0;
      model_burst(1'b0, 8'h50, 1);
      send_cmd(1'b0, 8'h50, 8'd1);
      t = 0;
      while (!rd_valid && t < 500) begin @(posedge clk); #1; t++; end
      chk("bp_rd_valid", rd_valid, 1'b1);
      repeat (40) begin @(posedge clk); #1; end
      chk("bp_one_access", got_addr.size(), 1);
      chk("bp_rd_held", rd_data, 16'h50AF);
      rd_ready = 1'b1;
      wait_idle();
      chk("bp_rd0", got_rd[0], 16'h50AF);
      chk("bp_rd1", got_rd[1], 16'h51AE);
      end_checks("bp");

      // Write starvation
      got_addr.delete();
      wd[0] = 16'h1234; wd[1] = 16'h5678; wd[2] = 16'h9ABC;
      model_burst(1'b1, 8'h30, 2);
      send_cmd(1'b1, 8'h30, 8'd2);
      for (int i = 0; i < 3; i++) push_wr(wd[i], 30);
      wait_idle();
      chk("starve_mem0", mem[8'h30], 16'h1234);
      chk("starve_mem1", mem[8'h31], 16'h5678);
      chk("starve_mem2", mem[8'h32], 16'h9ABC);
      chk("starve_addr2", got_addr[2], 8'h32);
      end_checks("starve");

      // Reset during WAIT of word 2 of 4
      model_burst(1'b0, 8'h40, 3);
      send_cmd(1'b0, 8'h40, 8'd3);
      t = 0;
      while (!(exp_acc.size() == 2 && mc_sel && !mc_ready) && t < 500) begin
         @(negedge clk); t++;
      end
      chk("midrst_in_wait", t < 500, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_reset("midrst");
      exp_acc.delete(); exp_rd.delete(); exp_done = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_no_done", done, 1'b0);
      wd[0] = 16'hBEEF;
      model_burst(1'b1, 8'h60, 0);
      send_cmd(1'b1, 8'h60, 8'd0);
      push_wr(16'hBEEF, 0);
      wait_idle();
      chk("midrst_new_cmd", mem[8'h60], 16'hBEEF);
      end_checks("midrst");

`ifdef MEM_BURST_TIMEOUT_EN
      // Timeout with mc_ready stuck high
      stuck = 1'b1; exp_err = 1'b1;
      exp_acc.push_back('{addr: 8'h20, we: 1'b0, wdata: 16'h0});
      exp_done = 1;
      send_cmd(1'b0, 8'h20, 8'd1);
      t = 0;
      while (!mc_sel && t < 50) begin @(posedge clk); #1; t++; end
      n = 0;
      while (mc_sel && n < 200) begin @(posedge clk); #1; n++; end
      chk("tmo_sel_cycles", n, TIMEOUT);
      chk("tmo_done", done, 1'b1);
      chk("tmo_err", err, 1'b1);
      chk("tmo_busy", busy, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      chk("tmo_no_rd", rd_valid, 1'b0);
      end_checks("tmo");
      stuck = 1'b0; exp_err = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
